// File: rtl/trap_sequencer_if.sv
// rtl/trap_sequencer_if.sv - commit-side request, CSR write port and redirect bundle of the trap sequencer
interface trap_sequencer_if #(
  parameter int XLEN       = 32,
  parameter int CODE_WIDTH = 5
);
  logic                  exc_req;
  logic [CODE_WIDTH-1:0] exc_code;
  logic [XLEN-1:0]       exc_tval;
  logic                  irq_req;
  logic [CODE_WIDTH-1:0] irq_code;
  logic                  xret_req;
  logic [1:0]            xret_priv;
  logic [XLEN-1:0]       commit_pc;
  logic [1:0]            next_priv;
  logic [XLEN-1:0]       xtvec;
  logic [XLEN-1:0]       xepc;
  logic                  mem_busy;
  logic                  csr_ready;
  logic                  csr_we;
  logic [11:0]           csr_waddr;
  logic [XLEN-1:0]       csr_wdata;
  logic                  req_ack;
  logic                  busy;
  logic                  flush;
  logic [XLEN-1:0]       next_pc;
  logic                  xret_commit;

  modport master (
    output exc_req, exc_code, exc_tval, irq_req, irq_code, xret_req, xret_priv,
           commit_pc, next_priv, xtvec, xepc, mem_busy, csr_ready,
    input  csr_we, csr_waddr, csr_wdata, req_ack, busy, flush, next_pc, xret_commit
  );

  modport slave (
    input  exc_req, exc_code, exc_tval, irq_req, irq_code, xret_req, xret_priv,
           commit_pc, next_priv, xtvec, xepc, mem_busy, csr_ready,
    output csr_we, csr_waddr, csr_wdata, req_ack, busy, flush, next_pc, xret_commit
  );
endinterface

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - trap entry / xRET sequencer: drain, xepc/xcause/xtval writes, single flush
// RAFI_TRAP_TVAL_EN adds the WR_TVAL stage; without it WR_CAUSE goes straight to REDIRECT.
module trap_sequencer #(
  parameter int XLEN       = 32,
  parameter int CODE_WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  trap_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_WR_EPC,
    S_WR_CAUSE,
`ifdef RAFI_TRAP_TVAL_EN
    S_WR_TVAL,
`endif
    S_REDIRECT
  } state_t;

  state_t state_q, state_d;

  logic                  is_irq_q;
  logic                  is_xret_q;
  logic [CODE_WIDTH-1:0] code_q;
  logic [1:0]            priv_q;
  logic [XLEN-1:1]       pc_q;
  logic                  any_req;
  logic                  accept;
  logic [3:0]            csr_hi;
  logic [XLEN-1:0]       cause_data;
  logic [XLEN-1:0]       tvec_base;
  logic [XLEN-1:0]       vec_off;
  logic [XLEN-1:0]       trap_target;

  assign any_req = bus.exc_req | bus.irq_req | bus.xret_req;
  assign accept  = (state_q == S_IDLE) && any_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef RAFI_TRAP_TVAL_EN
  logic [XLEN-1:0] tval_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tval_q <= '0;
    end else if (accept) begin
      tval_q <= (bus.exc_req) ? bus.exc_tval : '0;
    end
  end
`else
  logic unused_tval;
  assign unused_tval = ^bus.exc_tval;
`endif

  // Priority exc > irq > xret; the losers are simply not acknowledged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_irq_q  <= 1'b0;
      is_xret_q <= 1'b0;
      code_q    <= '0;
      priv_q    <= 2'b00;
      pc_q      <= '0;
    end else if (accept) begin
      pc_q <= bus.commit_pc[XLEN-1:1];
      if (bus.exc_req) begin
        is_irq_q  <= 1'b0;
        is_xret_q <= 1'b0;
        code_q    <= bus.exc_code;
        priv_q    <= bus.next_priv;
      end else if (bus.irq_req) begin
        is_irq_q  <= 1'b1;
        is_xret_q <= 1'b0;
        code_q    <= bus.irq_code;
        priv_q    <= bus.next_priv;
      end else begin
        is_irq_q  <= 1'b0;
        is_xret_q <= 1'b1;
        code_q    <= '0;
        priv_q    <= bus.xret_priv;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (any_req) state_d = S_DRAIN;
      S_DRAIN:    if (!bus.mem_busy) state_d = is_xret_q ? S_REDIRECT : S_WR_EPC;
      S_WR_EPC:   if (bus.csr_ready) state_d = S_WR_CAUSE;
`ifdef RAFI_TRAP_TVAL_EN
      S_WR_CAUSE: if (bus.csr_ready) state_d = S_WR_TVAL;
      S_WR_TVAL:  if (bus.csr_ready) state_d = S_REDIRECT;
`else
      S_WR_CAUSE: if (bus.csr_ready) state_d = S_REDIRECT;
`endif
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Reserved privilege 2'b10 falls back to the M-mode CSR block.
  assign csr_hi = (priv_q == 2'b01) ? 4'h1 :
                  (priv_q == 2'b00) ? 4'h0 : 4'h3;

  assign cause_data  = {is_irq_q, {(XLEN-1-CODE_WIDTH){1'b0}}, code_q};
  assign tvec_base   = {bus.xtvec[XLEN-1:2], 2'b00};
  assign vec_off     = {{(XLEN-CODE_WIDTH){1'b0}}, code_q} << 2;
  assign trap_target = (is_irq_q && bus.xtvec[1:0] == 2'b01) ? tvec_base + vec_off : tvec_base;

  always_comb begin
    bus.csr_we      = 1'b0;
    bus.csr_waddr   = 12'h000;
    bus.csr_wdata   = '0;
    bus.req_ack     = 1'b0;
    bus.busy        = (state_q != S_IDLE);
    bus.flush       = 1'b0;
    bus.next_pc     = '0;
    bus.xret_commit = 1'b0;
    case (state_q)
      S_IDLE: bus.req_ack = rst & any_req;
      S_WR_EPC: begin
        bus.csr_we    = 1'b1;
        bus.csr_waddr = {csr_hi, 8'h41};
        bus.csr_wdata = {pc_q, 1'b0};
      end
      S_WR_CAUSE: begin
        bus.csr_we    = 1'b1;
        bus.csr_waddr = {csr_hi, 8'h42};
        bus.csr_wdata = cause_data;
      end
`ifdef RAFI_TRAP_TVAL_EN
      S_WR_TVAL: begin
        bus.csr_we    = 1'b1;
        bus.csr_waddr = {csr_hi, 8'h43};
        bus.csr_wdata = tval_q;
      end
`endif
      S_REDIRECT: begin
        bus.flush       = 1'b1;
        bus.next_pc     = is_xret_q ? bus.xepc : trap_target;
        bus.xret_commit = is_xret_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed scoreboard bench for trap_sequencer (honours RAFI_TRAP_TVAL_EN)
module tb_trap_sequencer;
  localparam int XLEN = 32;
  localparam int CW   = 5;
`ifdef RAFI_TRAP_TVAL_EN
  localparam int TV = 1;
`else
  localparam int TV = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  trap_sequencer_if #(.XLEN(XLEN), .CODE_WIDTH(CW)) bus ();
  trap_sequencer #(.XLEN(XLEN), .CODE_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [11:0] addr; logic [31:0] data; } csr_t;
  typedef struct { int cyc; logic [31:0] pc; logic xr; } fl_t;

  csr_t csr_q[$];
  fl_t  fl_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_n = 0;
  int   ack_count = 0;
  int   t0;
  logic        prev_stall = 1'b0;
  logic [11:0] prev_addr  = '0;
  logic [31:0] prev_data  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_csr(input logic [11:0] a, input logic [31:0] d);
    csr_t e;
    e.addr = a; e.data = d;
    csr_q.push_back(e);
  endtask

  task automatic push_fl(input int c, input logic [31:0] pc, input logic xr);
    fl_t f;
    f.cyc = c; f.pc = pc; f.xr = xr;
    fl_q.push_back(f);
  endtask

  task automatic monitor();
    csr_t e;
    fl_t  f;
    if (bus.req_ack) ack_count++;
    if (bus.csr_we && prev_stall) begin
      check("csr_waddr_stable", 64'(bus.csr_waddr), 64'(prev_addr));
      check("csr_wdata_stable", 64'(bus.csr_wdata), 64'(prev_data));
    end
    if (bus.csr_we && bus.csr_ready) begin
      check("csr_write_expected", 64'(csr_q.size() != 0), 64'(1));
      if (csr_q.size() != 0) begin
        e = csr_q.pop_front();
        check("csr_waddr", 64'(bus.csr_waddr), 64'(e.addr));
        check("csr_wdata", 64'(bus.csr_wdata), 64'(e.data));
      end
    end
    prev_stall = bus.csr_we && !bus.csr_ready;
    prev_addr  = bus.csr_waddr;
    prev_data  = bus.csr_wdata;
    if (bus.flush) begin
      check("flush_expected", 64'(fl_q.size() != 0), 64'(1));
      if (fl_q.size() != 0) begin
        f = fl_q.pop_front();
        check("flush_cycle", 64'(cyc_n), 64'(f.cyc));
        check("next_pc", 64'(bus.next_pc), 64'(f.pc));
        check("xret_commit", 64'(bus.xret_commit), 64'(f.xr));
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (fl_q.size() != 0 && n < max) begin
      cyc();
      n++;
    end
    check("flush_timeout", 64'(fl_q.size()), 64'(0));
    check("csr_writes_done", 64'(csr_q.size()), 64'(0));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.exc_req = 0; bus.exc_code = '0; bus.exc_tval = '0;
    bus.irq_req = 0; bus.irq_code = '0;
    bus.xret_req = 0; bus.xret_priv = 2'b00;
    bus.commit_pc = '0; bus.next_priv = 2'b11;
    bus.xtvec = '0; bus.xepc = '0;
    bus.mem_busy = 0; bus.csr_ready = 1;

    // reset state
    #1;
    check("rst_csr_we", 64'(bus.csr_we), 64'(0));
    check("rst_csr_waddr", 64'(bus.csr_waddr), 64'(0));
    check("rst_csr_wdata", 64'(bus.csr_wdata), 64'(0));
    check("rst_req_ack", 64'(bus.req_ack), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_flush", 64'(bus.flush), 64'(0));
    check("rst_next_pc", 64'(bus.next_pc), 64'(0));
    check("rst_xret_commit", 64'(bus.xret_commit), 64'(0));
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    // M-mode exception
    ack_count = 0; t0 = cyc_n;
    bus.next_priv = 2'b11; bus.exc_code = 5'd2; bus.commit_pc = 32'h8000_0104;
    bus.exc_tval = 32'hDEAD_BEEF; bus.xtvec = 32'h8000_1001; bus.exc_req = 1;
    push_csr(12'h341, 32'h8000_0104);
    push_csr(12'h342, 32'h0000_0002);
`ifdef RAFI_TRAP_TVAL_EN
    push_csr(12'h343, 32'hDEAD_BEEF);
`endif
    push_fl(t0 + 4 + TV, 32'h8000_1000, 1'b0);
    check("m_busy_at_T", 64'(bus.busy), 64'(0));
    cyc();
    bus.exc_req = 0;
    check("m_busy_at_T1", 64'(bus.busy), 64'(1));
    drain(20);
    check("m_busy_after", 64'(bus.busy), 64'(0));
    check("m_ack_count", 64'(ack_count), 64'(1));

    // vectored S-mode interrupt
    ack_count = 0; t0 = cyc_n;
    bus.next_priv = 2'b01; bus.irq_code = 5'd7; bus.commit_pc = 32'h0000_1235;
    bus.exc_tval = 32'h1234_5678; bus.xtvec = 32'h0040_0001; bus.irq_req = 1;
    push_csr(12'h141, 32'h0000_1234);
    push_csr(12'h142, 32'h8000_0007);
`ifdef RAFI_TRAP_TVAL_EN
    push_csr(12'h143, 32'h0000_0000);
`endif
    push_fl(t0 + 4 + TV, 32'h0040_001C, 1'b0);
    cyc();
    bus.irq_req = 0;
    drain(20);
    check("irq_ack_count", 64'(ack_count), 64'(1));

    // simultaneous requests held through the whole sequence
    ack_count = 0; t0 = cyc_n;
    bus.next_priv = 2'b11; bus.xret_priv = 2'b01;
    bus.exc_code = 5'd5; bus.irq_code = 5'd3; bus.commit_pc = 32'h8000_0400;
    bus.exc_tval = 32'hCAFE_F00D; bus.xtvec = 32'h8000_2000; bus.xepc = 32'h0BAD_0000;
    bus.exc_req = 1; bus.irq_req = 1; bus.xret_req = 1;
    push_csr(12'h341, 32'h8000_0400);
    push_csr(12'h342, 32'h0000_0005);
`ifdef RAFI_TRAP_TVAL_EN
    push_csr(12'h343, 32'hCAFE_F00D);
`endif
    push_fl(t0 + 4 + TV, 32'h8000_2000, 1'b0);
    cyc();
    drain(20);
    check("sim_ack_once", 64'(ack_count), 64'(1));
    check("sim_reaccept_first_idle", 64'(bus.req_ack), 64'(1));
    t0 = cyc_n;
    push_csr(12'h341, 32'h8000_0400);
    push_csr(12'h342, 32'h0000_0005);
`ifdef RAFI_TRAP_TVAL_EN
    push_csr(12'h343, 32'hCAFE_F00D);
`endif
    push_fl(t0 + 4 + TV, 32'h8000_2000, 1'b0);
    cyc();
    bus.exc_req = 0; bus.irq_req = 0; bus.xret_req = 0;
    drain(20);
    check("sim_ack_twice", 64'(ack_count), 64'(2));

    // backpressure: mem_busy 3 cycles in DRAIN, csr_ready low 2 cycles in WR_CAUSE
    ack_count = 0; t0 = cyc_n;
    bus.next_priv = 2'b00; bus.exc_code = 5'd13; bus.commit_pc = 32'h0000_2000;
    bus.exc_tval = 32'h0000_ABCD; bus.xtvec = 32'h0000_3001;
    bus.exc_req = 1; bus.mem_busy = 1;
    push_csr(12'h041, 32'h0000_2000);
    push_csr(12'h042, 32'h0000_000D);
`ifdef RAFI_TRAP_TVAL_EN
    push_csr(12'h043, 32'h0000_ABCD);
`endif
    push_fl(t0 + 9 + TV, 32'h0000_3000, 1'b0);
    cyc();
    bus.exc_req = 0;
    cyc(); cyc(); cyc();
    bus.mem_busy = 0;
    cyc(); cyc();
    bus.csr_ready = 0;
    cyc(); cyc();
    bus.csr_ready = 1;
    drain(20);
    check("bp_ack_count", 64'(ack_count), 64'(1));

    // xRET, xepc sampled late
    ack_count = 0; t0 = cyc_n;
    bus.xret_priv = 2'b11; bus.next_priv = 2'b01; bus.xepc = 32'h1111_1110;
    bus.xret_req = 1;
    push_fl(t0 + 2, 32'h8000_0200, 1'b1);
    cyc();
    bus.xret_req = 0; bus.xepc = 32'h8000_0200;
    drain(10);
    check("xret_ack_count", 64'(ack_count), 64'(1));

    // reset during WR_EPC
    ack_count = 0;
    bus.next_priv = 2'b11; bus.exc_code = 5'd1; bus.commit_pc = 32'h8000_0500;
    bus.exc_req = 1;
    cyc();
    bus.exc_req = 0; bus.csr_ready = 0;
    cyc();
    check("rstmid_in_wr_epc", 64'(bus.csr_we), 64'(1));
    rst = 1'b0;
    #1;
    check("rstmid_csr_we", 64'(bus.csr_we), 64'(0));
    check("rstmid_csr_waddr", 64'(bus.csr_waddr), 64'(0));
    check("rstmid_csr_wdata", 64'(bus.csr_wdata), 64'(0));
    check("rstmid_busy", 64'(bus.busy), 64'(0));
    check("rstmid_flush", 64'(bus.flush), 64'(0));
    check("rstmid_next_pc", 64'(bus.next_pc), 64'(0));
    cyc();
    rst = 1'b1; bus.csr_ready = 1;
    for (int i = 0; i < 8; i++) cyc();
    check("rstmid_no_ack_after", 64'(ack_count), 64'(1));

    ack_count = 0; t0 = cyc_n;
    bus.next_priv = 2'b01; bus.exc_code = 5'd4; bus.commit_pc = 32'h0000_5000;
    bus.exc_tval = 32'h0000_0055; bus.xtvec = 32'h0000_6000; bus.exc_req = 1;
    push_csr(12'h141, 32'h0000_5000);
    push_csr(12'h142, 32'h0000_0004);
`ifdef RAFI_TRAP_TVAL_EN
    push_csr(12'h143, 32'h0000_0055);
`endif
    push_fl(t0 + 4 + TV, 32'h0000_6000, 1'b0);
    cyc();
    bus.exc_req = 0;
    drain(20);
    check("post_rst_ack_count", 64'(ack_count), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Multi-cycle sequencer for trap entry and trap return in the Rafi core. It accepts an exception, interrupt or xRET from the commit point and freezes the pipeline. It drains outstanding memory traffic, then writes xepc/xcause/xtval through the shared CSR write port. Finally it issues a single flush with the redirect PC. It sits between the EX/commit stage and the pipeline controller, replacing single-cycle trap redirection.

## Interface
Parameters:
- XLEN, 32, address/data width
- CODE_WIDTH, 5, trap cause code width

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- exc_req  in  1  synchronous exception at commit
- exc_code  in  CODE_WIDTH  exception cause
- exc_tval  in  XLEN  faulting address/instruction
- irq_req  in  1  enabled interrupt pending
- irq_code  in  CODE_WIDTH  interrupt cause
- xret_req  in  1  MRET/SRET/URET at commit
- xret_priv  in  2  privilege of xRET
- commit_pc  in  XLEN  PC of the committing instruction
- next_priv  in  2  trap target privilege (from CSR)
- xtvec  in  XLEN  tvec of next_priv
- xepc  in  XLEN  epc of xret_priv
- mem_busy  in  1  LSU has outstanding access
- csr_ready  in  1  CSR write accepted this cycle
- csr_we  out  1  CSR write request
- csr_waddr  out  12  CSR address
- csr_wdata  out  XLEN  CSR write data
- req_ack  out  1  request accepted (1-cycle pulse)
- busy  out  1  sequencer not idle; stalls all stages
- flush  out  1  pipeline flush (1-cycle pulse)
- next_pc  out  XLEN  redirect target, valid with flush
- xret_commit  out  1  privilege restore strobe, with flush for xRET

## Operation
- States: IDLE, DRAIN, WR_EPC, WR_CAUSE, WR_TVAL, REDIRECT.
- IDLE accept priority: exc_req > irq_req > xret_req. On acceptance:
  - latch kind, code, tval, commit_pc, next_priv/xret_priv;
  - pulse req_ack;
  - go to DRAIN.
- Requests are ignored while busy.
- DRAIN: remain while mem_busy=1. Exit when mem_busy=0: to WR_EPC for a trap, to REDIRECT for an xRET.
- WR_* states:
  - hold csr_we=1 with address and data stable;
  - advance only on a cycle with csr_ready=1.
- CSR addresses by latched priv: M: 0x341/0x342/0x343; S: 0x141/0x142/0x143; U: 0x041/0x042/0x043. Priv 2'b10 (reserved) uses M.
- xepc data = {pc[XLEN-1:1],1'b0}.
- xcause data = {is_irq, zeros, code}.
- xtval data = exc_tval for exceptions, 0 for interrupts.
- Trap target:
  - base = {xtvec[XLEN-1:2],2'b00};
  - when xtvec[1:0]=01 and interrupt: target = base + (code<<2), modulo 2^XLEN;
  - otherwise target = base.
- xtvec is sampled in REDIRECT.
- xRET target = xepc sampled in REDIRECT.
- REDIRECT: flush=1 and next_pc valid for exactly one cycle; xret_commit=1 if xRET; next state IDLE.

## Timing
- Reset (rst=0, async): state IDLE. All outputs 0: csr_we, csr_waddr, csr_wdata, req_ack, busy, flush, next_pc, xret_commit.
- rst asserted mid-sequence aborts immediately, with no partial flush pulse.
- busy = (state != IDLE), registered. req_ack is asserted in the acceptance cycle T.
- Trap with mem_busy=0 and csr_ready always 1:
  - DRAIN at T+1, WR_EPC T+2, WR_CAUSE T+3, WR_TVAL T+4;
  - flush at T+5; busy drops at T+6.
- xRET with mem_busy=0: DRAIN at T+1, flush at T+2.
- Each cycle of mem_busy=1 in DRAIN, or csr_ready=0 in WR_*, adds one cycle.
- A new request can be accepted in the first IDLE cycle after REDIRECT.

## Configuration
- RAFI_TRAP_TVAL_EN defined: WR_TVAL state is present; trap latency is as above.
- RAFI_TRAP_TVAL_EN undefined: WR_TVAL is removed; WR_CAUSE goes directly to REDIRECT; exc_tval is unused; trap flush occurs at T+4.

## Test plan
- M exception: exc_req, code 2, commit_pc 0x80000104, tval 0xDEADBEEF, xtvec 0x80001001, mem_busy=0, csr_ready=1. Required response:
  - writes 0x341=0x80000104, 0x342=0x00000002, 0x343=0xDEADBEEF;
  - flush at T+5 with next_pc 0x80001000.
- Vectored interrupt: irq_req, code 7, next_priv S, stvec 0x00400001. Required response:
  - writes 0x141, 0x142=0x80000007, 0x143=0;
  - next_pc 0x0040001C.
- Simultaneous exc_req, irq_req and xret_req: exception taken; req_ack once; other requests ignored until IDLE.
- Backpressure: mem_busy high 3 cycles and csr_ready low 2 cycles on WR_CAUSE. Required response: flush at T+10; csr_waddr/csr_wdata stable while stalled.
- xRET: xret_priv M, mepc 0x80000200. Required response: no CSR writes; flush, xret_commit and next_pc=0x80000200 at T+2.
- rst pulsed low during WR_EPC: outputs 0 immediately; no flush; next exc_req is accepted normally.
